// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall interlock: ID/EX/MEM observation
// signals in, stall/flush controls and multiply/divide status out.
interface hazard_stall_unit_if #(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid;
   logic [REG_ADDR_W-1:0]  id_rs;
   logic [REG_ADDR_W-1:0]  id_rt;
   logic                   id_uses_rs;
   logic                   id_uses_rt;
   logic                   id_is_branch;
   logic                   id_is_md;
   logic                   id_reads_hilo;
   logic                   ex_valid;
   logic [REG_ADDR_W-1:0]  ex_rd;
   logic                   ex_reg_write;
   logic                   ex_mem_read;
   logic [REG_ADDR_W-1:0]  mem_rd;
   logic                   mem_mem_read;
   logic                   branch_taken;

   logic                   pc_write;
   logic                   ifid_write;
   logic                   ifid_flush;
   logic                   idex_bubble;
   logic                   md_busy;
   logic [STALL_CNT_W-1:0] stall_count;
   // Debug view of the stall state: 0 RUN, 1 LOAD_STALL, 2 BRANCH_STALL, 3 MD_WAIT.
   logic [1:0]             dbg_state;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
             id_is_md, id_reads_hilo, ex_valid, ex_rd, ex_reg_write,
             ex_mem_read, mem_rd, mem_mem_read, branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy,
             stall_count, dbg_state
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch,
             id_is_md, id_reads_hilo, ex_valid, ex_rd, ex_reg_write,
             ex_mem_read, mem_rd, mem_mem_read, branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy,
             stall_count, dbg_state
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Interlock beside the ID stage: stalls PC/IF/ID and bubbles ID/EX for hazards
// forwarding cannot cover (load-use, ID branch operands, busy mult/div unit).
module hazard_stall_unit #(
   parameter int REG_ADDR_W  = 5,
   parameter int MD_LATENCY  = 32,
   parameter int STALL_CNT_W = 16
) (
   input logic                clock,
   input logic                reset_n,
   hazard_stall_unit_if.slave hz
);

   typedef enum logic [1:0] {
      ST_RUN          = 2'd0,
      ST_LOAD_STALL   = 2'd1,
      ST_BRANCH_STALL = 2'd2,
      ST_MD_WAIT      = 2'd3
   } stall_state_e;

   localparam logic [7:0]             MD_LAT_C  = 8'(MD_LATENCY);
   localparam logic [REG_ADDR_W-1:0]  REG_ZERO_C = {REG_ADDR_W{1'b0}};
   localparam logic [STALL_CNT_W-1:0] CNT_MAX_C = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] CNT_ONE_C = STALL_CNT_W'(1);

   // Register 0 is hardwired, so a write to it can never create a hazard.
   function automatic logic src_match(
      input logic                  valid,
      input logic                  uses_rs,
      input logic                  uses_rt,
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] rt,
      input logic [REG_ADDR_W-1:0] r
   );
      return valid && (r != REG_ZERO_C) &&
             ((uses_rs && (rs == r)) || (uses_rt && (rt == r)));
   endfunction

   logic [7:0]             md_cnt_q, md_cnt_d;
   stall_state_e           state_q, state_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic match_ex_s, match_mem_s;
   logic load_use_s, br_haz_s, md_haz_s, stall_s, md_busy_s;

   // Hazard detection from the current ID/EX/MEM contents.
   always_comb begin
      md_busy_s   = (md_cnt_q != 8'd0);
      match_ex_s  = src_match(hz.id_valid, hz.id_uses_rs, hz.id_uses_rt,
                              hz.id_rs, hz.id_rt, hz.ex_rd);
      match_mem_s = src_match(hz.id_valid, hz.id_uses_rs, hz.id_uses_rt,
                              hz.id_rs, hz.id_rt, hz.mem_rd);
      load_use_s  = hz.ex_valid & hz.ex_mem_read & match_ex_s;
      br_haz_s    = hz.id_is_branch &
                    ((hz.ex_valid & hz.ex_reg_write & match_ex_s) |
                     (hz.mem_mem_read & match_mem_s));
      md_haz_s    = hz.id_valid & (hz.id_is_md | hz.id_reads_hilo) & md_busy_s;
      stall_s     = load_use_s | br_haz_s | md_haz_s;
   end

   // Pipeline controls; held in the safe frozen/bubble state while in reset.
   always_comb begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.ifid_flush  = 1'b0;
      hz.idex_bubble = 1'b1;
      if (!reset_n) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.ifid_flush  = 1'b0;
         hz.idex_bubble = 1'b1;
      end else begin
         hz.pc_write    = ~stall_s;
         hz.ifid_write  = ~stall_s;
         hz.ifid_flush  = hz.branch_taken & ~stall_s;
         hz.idex_bubble = stall_s;
      end
   end

   // Next-state for the mult/div busy counter, stall FSM and stall counter.
   always_comb begin
      md_cnt_d    = md_cnt_q;
      state_d     = ST_RUN;
      stall_cnt_d = stall_cnt_q;

      if (hz.id_valid && hz.id_is_md && !stall_s) begin
         md_cnt_d = MD_LAT_C;
      end else if (md_cnt_q != 8'd0) begin
         md_cnt_d = md_cnt_q - 8'd1;
      end else begin
         md_cnt_d = 8'd0;
      end

      // A branch behind a load sees load_use first, then br_haz via MEM.
      if (load_use_s) begin
         state_d = ST_LOAD_STALL;
      end else if (br_haz_s) begin
         state_d = ST_BRANCH_STALL;
      end else if (md_haz_s) begin
         state_d = ST_MD_WAIT;
      end else begin
         state_d = ST_RUN;
      end

      if (stall_s && (stall_cnt_q != CNT_MAX_C)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE_C;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers; reset aborts any busy period or stall in progress.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         md_cnt_q    <= 8'd0;
         state_q     <= ST_RUN;
         stall_cnt_q <= {STALL_CNT_W{1'b0}};
      end else begin
         md_cnt_q    <= md_cnt_d;
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.md_busy     = md_busy_s;
   assign hz.stall_count = stall_cnt_q;
   assign hz.dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with MD_LATENCY=4 and a 4-bit stall counter.
module tb_hazard_stall_unit;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   hazard_stall_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(4)) hif ();

   hazard_stall_unit #(
      .REG_ADDR_W (5),
      .MD_LATENCY (4),
      .STALL_CNT_W(4)
   ) dut (
      .clock  (clk),
      .reset_n(rst_n),
      .hz     (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hif.id_valid = 1'b0;      hif.id_rs = 5'd0;          hif.id_rt = 5'd0;
      hif.id_uses_rs = 1'b0;    hif.id_uses_rt = 1'b0;     hif.id_is_branch = 1'b0;
      hif.id_is_md = 1'b0;      hif.id_reads_hilo = 1'b0;  hif.ex_valid = 1'b0;
      hif.ex_rd = 5'd0;         hif.ex_reg_write = 1'b0;   hif.ex_mem_read = 1'b0;
      hif.mem_rd = 5'd0;        hif.mem_mem_read = 1'b0;   hif.branch_taken = 1'b0;
   endtask

   task automatic load_use_vec(input logic [4:0] r);
      idle();
      hif.ex_valid = 1'b1; hif.ex_mem_read = 1'b1; hif.ex_reg_write = 1'b1; hif.ex_rd = r;
      hif.id_valid = 1'b1; hif.id_uses_rs = 1'b1;  hif.id_rs = r;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      load_use_vec(5'd8);
      hif.branch_taken = 1'b1;
      #3;
      chk("rst_pc_write", 32'(hif.pc_write), 32'd0);
      chk("rst_ifid_write", 32'(hif.ifid_write), 32'd0);
      chk("rst_flush", 32'(hif.ifid_flush), 32'd0);
      chk("rst_bubble", 32'(hif.idex_bubble), 32'd1);
      chk("rst_md_busy", 32'(hif.md_busy), 32'd0);
      chk("rst_count", 32'(hif.stall_count), 32'd0);
      idle();
      #9 rst_n = 1'b1;
      tick();
      chk("run_pc_write", 32'(hif.pc_write), 32'd1);
      chk("run_state", 32'(hif.dbg_state), 32'd0);

      // load-use on r8
      load_use_vec(5'd8);
      #1;
      chk("lu_pc_write", 32'(hif.pc_write), 32'd0);
      chk("lu_ifid_write", 32'(hif.ifid_write), 32'd0);
      chk("lu_bubble", 32'(hif.idex_bubble), 32'd1);
      tick();
      chk("lu_state", 32'(hif.dbg_state), 32'd1);
      chk("lu_count", 32'(hif.stall_count), 32'd1);
      hif.ex_valid = 1'b0;
      #1;
      chk("lu_release_pc", 32'(hif.pc_write), 32'd1);
      chk("lu_release_bubble", 32'(hif.idex_bubble), 32'd0);
      tick();
      chk("lu_count_hold", 32'(hif.stall_count), 32'd1);

      // r0 and unused-operand cases do not stall; rt use does
      load_use_vec(5'd0);
      #1;
      chk("r0_bubble", 32'(hif.idex_bubble), 32'd0);
      load_use_vec(5'd9);
      hif.id_uses_rs = 1'b0; hif.id_rs = 5'd0; hif.id_rt = 5'd9;
      #1;
      chk("rt_unused_bubble", 32'(hif.idex_bubble), 32'd0);
      hif.id_uses_rt = 1'b1;
      #1;
      chk("rt_used_bubble", 32'(hif.idex_bubble), 32'd1);
      tick();
      chk("rt_count", 32'(hif.stall_count), 32'd2);

      // beq on r5 behind a load: two stall cycles, taken ignored meanwhile
      load_use_vec(5'd5);
      hif.id_is_branch = 1'b1; hif.branch_taken = 1'b1;
      #1;
      chk("brld1_bubble", 32'(hif.idex_bubble), 32'd1);
      chk("brld1_flush", 32'(hif.ifid_flush), 32'd0);
      tick();
      chk("brld1_state", 32'(hif.dbg_state), 32'd1);
      hif.ex_valid = 1'b0; hif.ex_mem_read = 1'b0; hif.ex_reg_write = 1'b0;
      hif.mem_mem_read = 1'b1; hif.mem_rd = 5'd5;
      #1;
      chk("brld2_bubble", 32'(hif.idex_bubble), 32'd1);
      chk("brld2_flush", 32'(hif.ifid_flush), 32'd0);
      chk("brld2_pc", 32'(hif.pc_write), 32'd0);
      tick();
      chk("brld2_state", 32'(hif.dbg_state), 32'd2);
      chk("brld2_count", 32'(hif.stall_count), 32'd4);
      hif.mem_mem_read = 1'b0;
      #1;
      chk("brld3_flush", 32'(hif.ifid_flush), 32'd1);
      chk("brld3_pc", 32'(hif.pc_write), 32'd1);
      tick();
      chk("brld3_state", 32'(hif.dbg_state), 32'd0);

      // branch behind an ALU op stalls once; a plain ALU consumer forwards
      load_use_vec(5'd5);
      hif.ex_mem_read = 1'b0; hif.id_is_branch = 1'b1;
      #1;
      chk("bralu_bubble", 32'(hif.idex_bubble), 32'd1);
      tick();
      chk("bralu_state", 32'(hif.dbg_state), 32'd2);
      chk("bralu_count", 32'(hif.stall_count), 32'd5);
      hif.id_is_branch = 1'b0;
      #1;
      chk("alu_fwd_bubble", 32'(hif.idex_bubble), 32'd0);

      // mult accepted at t; mflo stalls t+1..t+4
      idle();
      hif.id_valid = 1'b1; hif.id_is_md = 1'b1;
      #1;
      chk("md_accept_pc", 32'(hif.pc_write), 32'd1);
      tick();
      hif.id_is_md = 1'b0; hif.id_reads_hilo = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk($sformatf("md_busy_t%0d", i), 32'(hif.md_busy), 32'd1);
         chk($sformatf("mflo_bubble_t%0d", i), 32'(hif.idex_bubble), 32'd1);
         tick();
         if (i == 1) chk("md_state", 32'(hif.dbg_state), 32'd3);
      end
      chk("md_busy_t5", 32'(hif.md_busy), 32'd0);
      chk("mflo_go_t5", 32'(hif.idex_bubble), 32'd0);
      chk("md_count", 32'(hif.stall_count), 32'd9);

      // second mult: accepted at t+5, next mult in final busy cycle waits one
      hif.id_reads_hilo = 1'b0; hif.id_is_md = 1'b1;
      #1;
      chk("mult2_accept", 32'(hif.idex_bubble), 32'd0);
      tick();
      hif.id_valid = 1'b0;
      tick(); tick(); tick();
      hif.id_valid = 1'b1;
      #1;
      chk("mult3_last_busy", 32'(hif.md_busy), 32'd1);
      chk("mult3_stall", 32'(hif.idex_bubble), 32'd1);
      tick();
      chk("mult3_accept", 32'(hif.idex_bubble), 32'd0);
      chk("mult3_count", 32'(hif.stall_count), 32'd10);
      tick();
      hif.id_is_md = 1'b0; hif.id_reads_hilo = 1'b1;
      tick();

      // async reset mid MD_WAIT with md_cnt = 3
      chk("pre_rst_state", 32'(hif.dbg_state), 32'd3);
      chk("pre_rst_count", 32'(hif.stall_count), 32'd11);
      rst_n = 1'b0;
      #1;
      chk("arst_md_busy", 32'(hif.md_busy), 32'd0);
      chk("arst_bubble", 32'(hif.idex_bubble), 32'd1);
      chk("arst_pc", 32'(hif.pc_write), 32'd0);
      #5 rst_n = 1'b1;
      #1;
      chk("post_rst_mflo", 32'(hif.idex_bubble), 32'd0);
      tick();
      chk("post_rst_state", 32'(hif.dbg_state), 32'd0);
      chk("post_rst_busy", 32'(hif.md_busy), 32'd0);

      // 20 stall cycles saturate a 4-bit counter
      load_use_vec(5'd12);
      for (int i = 0; i < 20; i++) tick();
      chk("sat_count", 32'(hif.stall_count), 32'd15);
      chk("sat_bubble", 32'(hif.idex_bubble), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
